// File: rtl/flag_oracle.sv
// flag_oracle: sequential responder for the per-byte flag-guess protocol.
// Accepts (index, guess) requests, answers match/no-match over a
// valid/ready response channel and keeps a sticky mask of solved bytes.
// Optional feature: define ORACLE_LOCKOUT_EN to lock out the requester for
// LOCKOUT_CYCLES cycles after LOCKOUT_THRESH consecutive wrong guesses.
module flag_oracle #(
    parameter int unsigned            FLAG_LEN       = 32,
    parameter int unsigned            IDX_W          = 5,
    parameter logic [8*FLAG_LEN-1:0]  FLAG           = "DUCTF{test_flag_0123456789abcde}",
    parameter int unsigned            LOCKOUT_THRESH = 16,
    parameter int unsigned            LOCKOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_idx,
    input  logic [7:0]          req_guess,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDX_W-1:0]    rsp_idx,
    output logic [7:0]          rsp_guess,
    output logic                rsp_match,
    output logic [FLAG_LEN-1:0] solved_mask,
    output logic                all_solved,
    output logic                locked
);

`ifdef ORACLE_LOCKOUT_EN
    localparam int unsigned MISS_W = $clog2(LOCKOUT_THRESH + 1);
    localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RSP  = 2'd2
`ifdef ORACLE_LOCKOUT_EN
        ,
        S_LOCK = 2'd3
`endif
    } state_t;

    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [IDX_W-1:0]      r_rsp_idx;
    logic [7:0]            r_rsp_guess;
    logic                  r_rsp_match;
    logic [FLAG_LEN-1:0]   r_solved_mask;

    logic [FLAG_LEN-1:0]   w_idx_hot;
    logic [FLAG_LEN-1:0]   w_hit;
    logic                  w_match;

`ifdef ORACLE_LOCKOUT_EN
    logic                  r_locked;
    logic [MISS_W-1:0]     r_miss_cnt;
    logic [LOCK_W-1:0]     r_lock_cnt;
    logic [MISS_W-1:0]     w_miss_next;
`endif

    // Reject illegal parameterisations at elaboration time
    if (FLAG_LEN < 1 || FLAG_LEN > (1 << IDX_W) || LOCKOUT_THRESH < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("flag_oracle: illegal parameter value");
    end

    // Per-byte decode of the latched index and compare against the constant flag byte;
    // indices with no flag byte decode to no hit and therefore never match
    for (genvar g = 0; g < int'(FLAG_LEN); g++) begin : g_byte
        assign w_idx_hot[g] = (r_rsp_idx == IDX_W'(g));
        assign w_hit[g]     = w_idx_hot[g] && (r_rsp_guess == FLAG[8*(int'(FLAG_LEN)-1-g) +: 8]);
    end

    assign w_match = |w_hit;

`ifdef ORACLE_LOCKOUT_EN
    // Saturating increment of the consecutive-miss count
    assign w_miss_next = (r_miss_cnt == MISS_W'(LOCKOUT_THRESH)) ? r_miss_cnt
                                                                 : r_miss_cnt + MISS_W'(1);
`endif

    // Protocol FSM with registered handshake, response and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_idx     <= '0;
            r_rsp_guess   <= '0;
            r_rsp_match   <= 1'b0;
            r_solved_mask <= '0;
`ifdef ORACLE_LOCKOUT_EN
            r_locked      <= 1'b0;
            r_miss_cnt    <= '0;
            r_lock_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_rsp_idx   <= req_idx;
                        r_rsp_guess <= req_guess;
                        r_req_ready <= 1'b0;
                        r_state     <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_rsp_match <= w_match;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_match) begin
                            r_solved_mask <= r_solved_mask | w_idx_hot;
                        end
`ifdef ORACLE_LOCKOUT_EN
                        r_miss_cnt <= r_rsp_match ? '0 : w_miss_next;
                        if (!r_rsp_match && (w_miss_next == MISS_W'(LOCKOUT_THRESH))) begin
                            r_state    <= S_LOCK;
                            r_locked   <= 1'b1;
                            r_lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
                        end else begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end
`else
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
`endif
                    end
                end
`ifdef ORACLE_LOCKOUT_EN
                S_LOCK: begin
                    if (r_lock_cnt == LOCK_W'(1)) begin
                        r_state     <= S_IDLE;
                        r_locked    <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_miss_cnt  <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - LOCK_W'(1);
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_idx     = r_rsp_idx;
    assign rsp_guess   = r_rsp_guess;
    assign rsp_match   = r_rsp_match;
    assign solved_mask = r_solved_mask;
    assign all_solved  = &r_solved_mask;
`ifdef ORACLE_LOCKOUT_EN
    assign locked      = r_locked;
`else
    assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_flag_oracle.sv
// tb_flag_oracle: scoreboard bench for flag_oracle (default parameters).
module tb_flag_oracle;

    localparam logic [255:0] FLAG_STR = "DUCTF{test_flag_0123456789abcde}";

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] guess;
        logic       match;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_idx;
    logic [7:0]  req_guess;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_idx;
    logic [7:0]  rsp_guess;
    logic        rsp_match;
    logic [31:0] solved_mask;
    logic        all_solved;
    logic        locked;

    int          n_checks;
    int          n_errors;
    int          cycle;
    exp_t        q_exp[$];
    logic [31:0] m_mask;

    flag_oracle dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_idx     (req_idx),
        .req_guess   (req_guess),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_idx     (rsp_idx),
        .rsp_guess   (rsp_guess),
        .rsp_match   (rsp_match),
        .solved_mask (solved_mask),
        .all_solved  (all_solved),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    function automatic logic exp_match(input logic [4:0] i, input logic [7:0] g);
        logic [255:0] t;
        t = FLAG_STR >> (8 * (31 - int'(i)));
        return g == t[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, push its expectation, wait for rsp_valid (bounded)
    task automatic do_req(input logic [4:0] idx, input logic [7:0] g, output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        n   = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            to = 1'b1;
            return;
        end
        req_valid = 1'b1;
        req_idx   = idx;
        req_guess = g;
        tick();
        req_valid = 1'b0;
        q_exp.push_back(exp_t'{idx: idx, guess: g, match: exp_match(idx, g)});
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!rsp_valid) to = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++;
        if ({rsp_idx, rsp_guess, rsp_match} !== 14'h0) begin
            n_errors++; $display("FAIL reset_rsp_fields: got idx=%0h guess=%0h match=%b expected all 0", rsp_idx, rsp_guess, rsp_match);
        end
        n_checks++;
        if (solved_mask !== 32'h0 || all_solved !== 1'b0) begin
            n_errors++; $display("FAIL reset_solved: got mask=%h all=%b expected 0/0", solved_mask, all_solved);
        end
        n_checks++;
        if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: got ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_match();
        int lat; bit to; exp_t e;
        rsp_ready = 1'b1;
        do_req(5'd0, 8'h44, lat, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL match_timeout: got timeout=%b expected 0", to); return; end
        n_checks++;
        if (lat !== 2) begin n_errors++; $display("FAIL match_latency: got %0d edges expected 2", lat); end
        e = q_exp.pop_front();
        n_checks++;
        if (rsp_match !== 1'b1 || rsp_idx !== 5'd0 || rsp_guess !== 8'h44) begin
            n_errors++; $display("FAIL match_fields: got idx=%0h guess=%h match=%b expected 0/44/1", rsp_idx, rsp_guess, rsp_match);
        end
        if (e.match) m_mask[e.idx] = 1'b1;
        tick();
        n_checks++;
        if (solved_mask !== 32'h1 || all_solved !== 1'b0) begin
            n_errors++; $display("FAIL match_mask: got mask=%h all=%b expected 00000001/0", solved_mask, all_solved);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL match_return_idle: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit to; exp_t e; bit bad;
        rsp_ready = 1'b0;
        do_req(5'd0, 8'h45, lat, to);
        n_checks++;
        if (to !== 1'b0) begin n_errors++; $display("FAIL bp_timeout: got timeout=%b expected 0", to); return; end
        e = q_exp.pop_front();
        // A would-be matching request held during RSP must not be consumed
        req_valid = 1'b1;
        req_idx   = 5'd3;
        req_guess = 8'h54;
        for (int i = 0; i < 10; i++) begin
            bad = (rsp_valid !== 1'b1) || (rsp_idx !== e.idx) || (rsp_guess !== e.guess) ||
                  (rsp_match !== e.match) || (req_ready !== 1'b0);
            n_checks++;
            if (bad) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b idx=%0h guess=%h match=%b ready=%b expected 1/%0h/%h/%b/0",
                         i, rsp_valid, rsp_idx, rsp_guess, rsp_match, req_ready, e.idx, e.guess, e.match);
            end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready);
        end
        repeat (4) tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || solved_mask !== m_mask) begin
            n_errors++; $display("FAIL bp_not_consumed: got valid=%b mask=%h expected 0/%h", rsp_valid, solved_mask, m_mask);
        end
    endtask

    task automatic test_async_reset();
        int lat; bit to; exp_t e;
        rsp_ready = 1'b1;
        do_req(5'd1, 8'h55, lat, to);
        if (!to) begin
            e = q_exp.pop_front();
            if (e.match) m_mask[e.idx] = 1'b1;
            tick();
        end
        n_checks++;
        if (solved_mask !== 32'h3) begin n_errors++; $display("FAIL arst_premask: got %h expected 00000003", solved_mask); end
        rsp_ready = 1'b0;
        do_req(5'd2, 8'h00, lat, to);
        n_checks++;
        if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL arst_in_rsp: got valid=%b expected 1", rsp_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || solved_mask !== 32'h0 || all_solved !== 1'b0) begin
            n_errors++; $display("FAIL arst_immediate: got valid=%b mask=%h all=%b expected 0/0/0", rsp_valid, solved_mask, all_solved);
        end
        tick();
        tick();
        rst = 1'b0;
        q_exp.delete();
        m_mask = 32'h0;
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || locked !== 1'b0) begin
            n_errors++; $display("FAIL arst_release: got ready=%b valid=%b locked=%b expected 1/0/0", req_ready, rsp_valid, locked);
        end
    endtask

    task automatic test_sweep();
        int lat; bit to; exp_t e; int n_match; logic [255:0] spelled; bit abort;
        n_match = 0;
        spelled = '0;
        abort   = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 32 && !abort; i++) begin
            for (int g = 0; g < 256 && !abort; g++) begin
                do_req(5'(i), 8'(g), lat, to);
                if (to) begin
                    n_checks++; n_errors++;
                    $display("FAIL sweep_timeout: idx=%0d guess=%0d no response", i, g);
                    abort = 1'b1;
                end else begin
                    e = q_exp.pop_front();
                    n_checks++;
                    if ({rsp_idx, rsp_guess, rsp_match} !== {e.idx, e.guess, e.match}) begin
                        n_errors++;
                        $display("FAIL sweep_rsp: got idx=%0h guess=%h match=%b expected %0h/%h/%b",
                                 rsp_idx, rsp_guess, rsp_match, e.idx, e.guess, e.match);
                    end
                    if (rsp_match === 1'b1) begin
                        n_match++;
                        spelled = {spelled[247:0], rsp_guess};
                    end
                    if (e.match) m_mask[e.idx] = 1'b1;
                    tick();
                    n_checks++;
                    if (all_solved !== (&m_mask)) begin
                        n_errors++; $display("FAIL sweep_all_solved: got %b expected %b at idx=%0d guess=%0d", all_solved, &m_mask, i, g);
                    end
                end
            end
        end
        n_checks++;
        if (n_match !== 32) begin n_errors++; $display("FAIL sweep_match_count: got %0d expected 32", n_match); end
        n_checks++;
        if (spelled !== FLAG_STR) begin n_errors++; $display("FAIL sweep_spelled: got %h expected %h", spelled, FLAG_STR); end
        n_checks++;
        if (solved_mask !== 32'hFFFF_FFFF || all_solved !== 1'b1) begin
            n_errors++; $display("FAIL sweep_final: got mask=%h all=%b expected ffffffff/1", solved_mask, all_solved);
        end
    endtask

`ifdef ORACLE_LOCKOUT_EN
    task automatic test_lockout();
        int lat; bit to; exp_t e; int n; bit saw_ready;
        rsp_ready = 1'b1;
        do_req(5'd0, 8'h44, lat, to);
        if (!to) begin e = q_exp.pop_front(); tick(); end
        for (int k = 0; k < 16; k++) begin
            do_req(5'd5, 8'h00, lat, to);
            n_checks++;
            if (to || rsp_match !== 1'b0 || locked !== 1'b0) begin
                n_errors++; $display("FAIL lock_miss[%0d]: got timeout=%b match=%b locked=%b expected 0/0/0", k, to, rsp_match, locked);
                return;
            end
            e = q_exp.pop_front();
            tick();
        end
        n = 0;
        saw_ready = 1'b0;
        while (locked === 1'b1 && n < 200) begin
            if (req_ready !== 1'b0) saw_ready = 1'b1;
            n++;
            tick();
        end
        n_checks++;
        if (n !== 64) begin n_errors++; $display("FAIL lock_duration: got %0d cycles expected 64", n); end
        n_checks++;
        if (saw_ready !== 1'b0) begin n_errors++; $display("FAIL lock_ready_low: got ready seen=%b expected 0", saw_ready); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL lock_exit_ready: got %b expected 1", req_ready); end
        do_req(5'd5, 8'h00, lat, to);
        n_checks++;
        if (to !== 1'b0 || lat !== 2) begin n_errors++; $display("FAIL lock_17th: got timeout=%b lat=%0d expected 0/2", to, lat); end
        if (!to) begin e = q_exp.pop_front(); tick(); end
        do_req(5'd0, 8'h44, lat, to);
        if (!to) begin e = q_exp.pop_front(); tick(); end
        // 15 misses, a match, then 15 more misses: never reaches the threshold
        for (int k = 0; k < 31; k++) begin
            if (k == 15) do_req(5'd0, 8'h44, lat, to);
            else         do_req(5'd5, 8'h00, lat, to);
            if (!to) begin e = q_exp.pop_front(); tick(); end
            n_checks++;
            if (to || locked !== 1'b0) begin
                n_errors++; $display("FAIL lock_reset_by_match[%0d]: got timeout=%b locked=%b expected 0/0", k, to, locked);
                return;
            end
        end
    endtask
`else
    task automatic test_no_lockout();
        int lat; bit to; exp_t e; int last;
        rsp_ready = 1'b1;
        last = 0;
        for (int k = 0; k < 1000; k++) begin
            do_req(5'd1, 8'h00, lat, to);
            n_checks++;
            if (to) begin n_errors++; $display("FAIL nolock_timeout[%0d]: no response", k); return; end
            e = q_exp.pop_front();
            n_checks++;
            if (rsp_match !== e.match || locked !== 1'b0) begin
                n_errors++; $display("FAIL nolock_rsp[%0d]: got match=%b locked=%b expected %b/0", k, rsp_match, locked, e.match);
            end
            if (k > 0) begin
                n_checks++;
                if (cycle - last !== 3) begin n_errors++; $display("FAIL nolock_spacing[%0d]: got %0d expected 3", k, cycle - last); end
            end
            last = cycle;
            tick();
        end
    endtask
`endif

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cycle     = 0;
        m_mask    = 32'h0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_idx   = 5'd0;
        req_guess = 8'h00;
        rsp_ready = 1'b0;
        test_reset();
        test_match();
        test_backpressure();
        test_async_reset();
        test_sweep();
`ifdef ORACLE_LOCKOUT_EN
        test_lockout();
`else
        test_no_lockout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
